m68k_bus_arbiter: RTL and testbench
===================================

// Module: m68k_bus_arbiter
// PURPOSE
//  Owns 68000 bus mastership for the Pi-side transaction engine. Implements the BR_n/BG_n/BGACK_n
//  three-wire arbitration so external DMA masters (Agnus, Zorro cards) can take the bus.
//  Gates when the transaction engine may leave S0, and when our AS/UDS/LDS/RW/address drivers may drive.
//  Sits between the PI register interface and the M68K bus state machine, all in the PI_CLK domain.
// PARAMETERS
//  BR_FILTER       2   consecutive M68K_CLK falling edges BR_n must be sampled low before it is honoured
//  RECOVER_CYCLES  2   M68K_CLK falling edges after bus return before our drivers re-enable
//  GRANT_TIMEOUT   32  M68K_CLK falling edges in GRANT without BGACK_n before the grant is withdrawn
//  HOLD_MAX        256 M68K_CLK falling edges of external ownership before HOLD_OVERRUN is flagged
// PORTS
//  PI_CLK          in   1  ~200 MHz system clock; sole clock
//  PI_RST          in   1  synchronous active-high reset
//  M68K_CLK        in   1  7 MHz bus clock, sampled as data (3-flop sync, falling-edge pulse c7m_fall)
//  M68K_BR_n       in   1  external bus request (2-flop sync)
//  M68K_BGACK_n    in   1  external bus grant acknowledge (2-flop sync)
//  TXN_REQ         in   1  transaction engine has a cycle to start
//  TXN_ACTIVE      in   1  transaction engine is in S1..S7 (AS_n cycle in flight)
//  STATUS_CLR      in   1  one-cycle pulse, clears HOLD_OVERRUN
//  TXN_GRANT       out  1  engine may leave S0 this c7m period
//  M68K_BG_n       out  1  bus grant to external master
//  BUS_DRIVE       out  1  1 = our bus control/address drivers enabled; 0 = tristated
//  EXT_MASTER      out  1  1 while state is GRANT or EXT
//  HOLD_OVERRUN    out  1  sticky: external hold exceeded HOLD_MAX
// BEHAVIOUR
//  Reset: state OWN, M68K_BG_n=1, BUS_DRIVE=1, TXN_GRANT=0, EXT_MASTER=0, HOLD_OVERRUN=0.
//   All counters and the fair bit reset to 0. BR_n/BGACK_n syncs reset to 1; c7m sync resets to 0.
//   Reset mid-operation aborts any state and returns to OWN; outputs take reset values 1 PI_CLK later.
//  br_ok: asserted after BR_FILTER consecutive c7m_fall samples of synced BR_n=0.
//   Deasserts on the first c7m_fall sample of BR_n=1.
//  State transitions occur only on PI_CLK cycles with c7m_fall=1. All outputs are registered and
//   reflect the state with 1 PI_CLK latency.
//  OWN:   BUS_DRIVE=1, BG_n=1, TXN_GRANT=TXN_REQ & !(br_ok & !fair).
//         If br_ok & !fair -> PEND.
//  PEND:  TXN_GRANT=0, BUS_DRIVE=1, BG_n=1.
//         If !br_ok -> OWN. Else if TXN_ACTIVE=0 -> GRANT. Else stay.
//  GRANT: BG_n=0, BUS_DRIVE=0, TXN_GRANT=0; grant counter increments on each c7m_fall.
//         Priority: BGACK_n=0 -> EXT; else !br_ok -> RECOV (cancelled); else counter==GRANT_TIMEOUT -> RECOV.
//  EXT:   BG_n=1, BUS_DRIVE=0; hold counter increments on each c7m_fall, saturating at HOLD_MAX.
//         HOLD_OVERRUN sets when the count reaches HOLD_MAX. BGACK_n=1 -> RECOV.
//  RECOV: BG_n=1, BUS_DRIVE=0; counts RECOVER_CYCLES c7m_falls, then -> OWN with fair=TXN_REQ.
//  Fairness: while fair=1, br_ok is ignored in OWN, guaranteeing one Pi cycle between external tenures.
//   fair clears on the c7m_fall where TXN_ACTIVE was seen high then low, or where TXN_REQ=0.
//  TXN_GRANT already high when br_ok rises: the cycle already started completes; PEND waits for TXN_ACTIVE=0.
//  STATUS_CLR coincident with the overrun set condition: set wins. Grant and hold counters clear on state entry.
// TESTING
//  1 Reset mid-EXT (PI_RST high 3 clks) -> next clk BG_n=1, BUS_DRIVE=1, EXT_MASTER=0, state OWN.
//  2 Idle engine, BR_n=0 -> OWN->PEND at 2nd c7m_fall, GRANT (BG_n=0, BUS_DRIVE=0) at 3rd.
//    Then BGACK_n=0 -> BG_n=1 at next fall; BGACK_n=1 -> BUS_DRIVE=1 exactly 2 falls later.
//  3 TXN_ACTIVE high for 5 c7m cycles when BR_n falls -> BG_n stays 1 and TXN_GRANT=0 until
//    the first fall after TXN_ACTIVE=0.
//  4 BR_n low then high in GRANT with BGACK_n=1 -> RECOV then OWN; no EXT entry; HOLD_OVERRUN=0.
//  5 BR_n low for 1 c7m_fall only -> no state change. BR_n back-to-back with TXN_REQ=1 after RECOV
//    -> one full TXN_ACTIVE cycle occurs before next BG_n=0.
//  6 HOLD_MAX=16, BGACK_n held low 20 falls -> HOLD_OVERRUN=1 at 16th fall, stays 1 until STATUS_CLR pulse.

Source files
------------

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus mastership arbiter: BR_n/BG_n/BGACK_n handshake against external DMA masters,
// gating the Pi transaction engine and our bus drivers. Single PI_CLK domain, M68K_CLK sampled as data.
module m68k_bus_arbiter #(
  parameter int unsigned BR_FILTER      = 2,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned GRANT_TIMEOUT  = 32,
  parameter int unsigned HOLD_MAX       = 256
) (
  input  logic PI_CLK,
  input  logic PI_RST,
  input  logic M68K_CLK,
  input  logic M68K_BR_n,
  input  logic M68K_BGACK_n,
  input  logic TXN_REQ,
  input  logic TXN_ACTIVE,
  input  logic STATUS_CLR,
  output logic TXN_GRANT,
  output logic M68K_BG_n,
  output logic BUS_DRIVE,
  output logic EXT_MASTER,
  output logic HOLD_OVERRUN
);

  localparam int unsigned CNT_MAX_A = (HOLD_MAX > GRANT_TIMEOUT) ? HOLD_MAX : GRANT_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > RECOVER_CYCLES) ? CNT_MAX_A : RECOVER_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned BRF_W     = $clog2(BR_FILTER + 1);

  typedef enum logic [2:0] {
    ST_OWN   = 3'd0,
    ST_PEND  = 3'd1,
    ST_GRANT = 3'd2,
    ST_EXT   = 3'd3,
    ST_RECOV = 3'd4
  } state_e;

  logic [2:0]       c7m_q;
  logic [1:0]       br_sync_q;
  logic [1:0]       bgack_sync_q;
  logic             c7m_fall;
  logic             br_s;
  logic             bgack_s;

  logic [BRF_W-1:0] br_cnt_q, br_cnt_d;
  logic             br_ok_c;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             fair_q, fair_d;
  logic             act_seen_q, act_seen_d;
  logic             ovr_set;

  logic             bg_n_q, bg_n_d;
  logic             bus_drive_q, bus_drive_d;
  logic             txn_grant_q, txn_grant_d;
  logic             ext_master_q, ext_master_d;
  logic             hold_overrun_q, hold_overrun_d;

  // Input synchronisers; c7m_fall is a one-PI_CLK pulse per M68K_CLK falling edge
  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      c7m_q        <= '0;
      br_sync_q    <= '1;
      bgack_sync_q <= '1;
    end else begin
      c7m_q        <= {c7m_q[1:0], M68K_CLK};
      br_sync_q    <= {br_sync_q[0], M68K_BR_n};
      bgack_sync_q <= {bgack_sync_q[0], M68K_BGACK_n};
    end
  end

  assign c7m_fall = c7m_q[2] & ~c7m_q[1];
  assign br_s     = br_sync_q[1];
  assign bgack_s  = bgack_sync_q[1];

  // BR_n glitch filter: count consecutive low samples, saturating at BR_FILTER
  always_comb begin
    br_cnt_d = br_cnt_q;
    if (c7m_fall) begin
      if (br_s) begin
        br_cnt_d = '0;
      end else if (br_cnt_q != BRF_W'(BR_FILTER)) begin
        br_cnt_d = br_cnt_q + BRF_W'(1);
      end
    end
  end

  assign br_ok_c = (br_cnt_d == BRF_W'(BR_FILTER));
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Arbitration state register
  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      state_q    <= ST_OWN;
      cnt_q      <= '0;
      fair_q     <= 1'b0;
      act_seen_q <= 1'b0;
      br_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fair_q     <= fair_d;
      act_seen_q <= act_seen_d;
      br_cnt_q   <= br_cnt_d;
    end
  end

  // Next state; everything advances only on c7m_fall
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fair_d     = fair_q;
    act_seen_d = act_seen_q | (fair_q & TXN_ACTIVE);
    ovr_set    = 1'b0;
    if (c7m_fall) begin
      case (state_q)
        ST_OWN: begin
          if (br_ok_c && !fair_q) state_d = ST_PEND;
        end
        ST_PEND: begin
          if (!br_ok_c)        state_d = ST_OWN;
          else if (!TXN_ACTIVE) state_d = ST_GRANT;
        end
        ST_GRANT: begin
          cnt_d = cnt_inc;
          if (!bgack_s)                               state_d = ST_EXT;
          else if (!br_ok_c)                          state_d = ST_RECOV;
          else if (cnt_inc == CNT_W'(GRANT_TIMEOUT))  state_d = ST_RECOV;
        end
        ST_EXT: begin
          if (cnt_q != CNT_W'(HOLD_MAX)) begin
            cnt_d   = cnt_inc;
            ovr_set = (cnt_inc == CNT_W'(HOLD_MAX));
          end
          if (bgack_s) state_d = ST_RECOV;
        end
        ST_RECOV: begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(RECOVER_CYCLES)) begin
            state_d    = ST_OWN;
            fair_d     = TXN_REQ;
            act_seen_d = 1'b0;
          end
        end
        default: state_d = ST_OWN;
      endcase
      // Fair window closes once our engine has run a full cycle or stopped asking
      if (fair_q && (!TXN_REQ || (act_seen_q && !TXN_ACTIVE))) begin
        fair_d     = 1'b0;
        act_seen_d = 1'b0;
      end
      if (state_d != state_q) cnt_d = '0;
    end
  end

  // Output decode from current state, registered below
  always_comb begin
    bg_n_d         = 1'b1;
    bus_drive_d    = 1'b1;
    txn_grant_d    = 1'b0;
    ext_master_d   = 1'b0;
    hold_overrun_d = hold_overrun_q;
    case (state_q)
      ST_OWN: begin
        txn_grant_d = TXN_REQ & ~(br_ok_c & ~fair_q);
      end
      ST_PEND: begin
        txn_grant_d = 1'b0;
      end
      ST_GRANT: begin
        bg_n_d       = 1'b0;
        bus_drive_d  = 1'b0;
        ext_master_d = 1'b1;
      end
      ST_EXT: begin
        bus_drive_d  = 1'b0;
        ext_master_d = 1'b1;
      end
      ST_RECOV: begin
        bus_drive_d = 1'b0;
      end
      default: begin
        bg_n_d      = 1'b1;
        bus_drive_d = 1'b1;
      end
    endcase
    // Set has priority over a coincident clear
    if (ovr_set)         hold_overrun_d = 1'b1;
    else if (STATUS_CLR) hold_overrun_d = 1'b0;
  end

  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      bg_n_q         <= 1'b1;
      bus_drive_q    <= 1'b1;
      txn_grant_q    <= 1'b0;
      ext_master_q   <= 1'b0;
      hold_overrun_q <= 1'b0;
    end else begin
      bg_n_q         <= bg_n_d;
      bus_drive_q    <= bus_drive_d;
      txn_grant_q    <= txn_grant_d;
      ext_master_q   <= ext_master_d;
      hold_overrun_q <= hold_overrun_d;
    end
  end

  assign M68K_BG_n    = bg_n_q;
  assign BUS_DRIVE    = bus_drive_q;
  assign TXN_GRANT    = txn_grant_q;
  assign EXT_MASTER   = ext_master_q;
  assign HOLD_OVERRUN = hold_overrun_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed bench for m68k_bus_arbiter: vector table of per-fall expectations plus
// hand sequences for hold overrun, reset mid-tenure and grant timeout.
module tb_m68k_bus_arbiter;

  logic PI_CLK = 1'b0;
  logic PI_RST;
  logic M68K_CLK;
  logic M68K_BR_n;
  logic M68K_BGACK_n;
  logic TXN_REQ;
  logic TXN_ACTIVE;
  logic STATUS_CLR;
  logic TXN_GRANT;
  logic M68K_BG_n;
  logic BUS_DRIVE;
  logic EXT_MASTER;
  logic HOLD_OVERRUN;

  int checks   = 0;
  int failures = 0;

  // in = {br_n, bgack_n, txn_req, txn_active}; exp = {bg_n, bus_drive, txn_grant, ext_master, hold_overrun}
  typedef struct packed {
    logic [3:0] in;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [42];

  m68k_bus_arbiter #(
    .BR_FILTER      (2),
    .RECOVER_CYCLES (2),
    .GRANT_TIMEOUT  (32),
    .HOLD_MAX       (16)
  ) dut (
    .PI_CLK       (PI_CLK),
    .PI_RST       (PI_RST),
    .M68K_CLK     (M68K_CLK),
    .M68K_BR_n    (M68K_BR_n),
    .M68K_BGACK_n (M68K_BGACK_n),
    .TXN_REQ      (TXN_REQ),
    .TXN_ACTIVE   (TXN_ACTIVE),
    .STATUS_CLR   (STATUS_CLR),
    .TXN_GRANT    (TXN_GRANT),
    .M68K_BG_n    (M68K_BG_n),
    .BUS_DRIVE    (BUS_DRIVE),
    .EXT_MASTER   (EXT_MASTER),
    .HOLD_OVERRUN (HOLD_OVERRUN)
  );

  always #5 PI_CLK = ~PI_CLK;

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {M68K_BG_n, BUS_DRIVE, TXN_GRANT, EXT_MASTER, HOLD_OVERRUN};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got {bg_n,drive,grant,ext,ovr}=%b expected=%b", name, got, exp);
    end
  endtask

  // One M68K_CLK period ending just after its falling edge has propagated to the outputs;
  // clr_on_fall pulses STATUS_CLR in exactly the PI_CLK cycle where the fall is acted on.
  task automatic do_fall(input logic clr_on_fall);
    M68K_CLK = 1'b1;
    repeat (5) @(negedge PI_CLK);
    M68K_CLK = 1'b0;
    repeat (2) @(negedge PI_CLK);
    STATUS_CLR = clr_on_fall;
    @(negedge PI_CLK);
    STATUS_CLR = 1'b0;
    repeat (2) @(negedge PI_CLK);
  endtask

  task automatic falls(input int n);
    for (int k = 0; k < n; k++) do_fall(1'b0);
  endtask

  task automatic set_in(input logic [3:0] in);
    {M68K_BR_n, M68K_BGACK_n, TXN_REQ, TXN_ACTIVE} = in;
  endtask

  initial begin
    // Arbitration walk-through from reset
    vecs[0]  = '{4'b1100, 5'b11000};
    vecs[1]  = '{4'b1110, 5'b11100};
    vecs[2]  = '{4'b0100, 5'b11000};
    vecs[3]  = '{4'b1100, 5'b11000};
    vecs[4]  = '{4'b0100, 5'b11000};
    vecs[5]  = '{4'b0100, 5'b11000};
    vecs[6]  = '{4'b0100, 5'b00010};
    vecs[7]  = '{4'b0000, 5'b10010};
    vecs[8]  = '{4'b1000, 5'b10010};
    vecs[9]  = '{4'b1100, 5'b10000};
    vecs[10] = '{4'b1100, 5'b10000};
    vecs[11] = '{4'b1100, 5'b11000};
    // Request withdrawn during grant
    vecs[12] = '{4'b0100, 5'b11000};
    vecs[13] = '{4'b0100, 5'b11000};
    vecs[14] = '{4'b0100, 5'b00010};
    vecs[15] = '{4'b1100, 5'b10000};
    vecs[16] = '{4'b1100, 5'b10000};
    vecs[17] = '{4'b1100, 5'b11000};
    // Tenure with engine pending, then fair window
    vecs[18] = '{4'b0110, 5'b11100};
    vecs[19] = '{4'b0110, 5'b11000};
    vecs[20] = '{4'b0110, 5'b00010};
    vecs[21] = '{4'b0010, 5'b10010};
    vecs[22] = '{4'b1110, 5'b10000};
    vecs[23] = '{4'b1110, 5'b10000};
    vecs[24] = '{4'b1110, 5'b11100};
    vecs[25] = '{4'b0110, 5'b11100};
    vecs[26] = '{4'b0111, 5'b11100};
    vecs[27] = '{4'b0100, 5'b11000};
    vecs[28] = '{4'b0100, 5'b11000};
    vecs[29] = '{4'b0100, 5'b00010};
    vecs[30] = '{4'b1100, 5'b10000};
    vecs[31] = '{4'b1100, 5'b10000};
    vecs[32] = '{4'b1100, 5'b11000};
    // BR_n falls while our cycle is active for 5 c7m periods
    vecs[33] = '{4'b0111, 5'b11100};
    vecs[34] = '{4'b0111, 5'b11000};
    vecs[35] = '{4'b0111, 5'b11000};
    vecs[36] = '{4'b0111, 5'b11000};
    vecs[37] = '{4'b0111, 5'b11000};
    vecs[38] = '{4'b0100, 5'b00010};
    vecs[39] = '{4'b1100, 5'b10000};
    vecs[40] = '{4'b1100, 5'b10000};
    vecs[41] = '{4'b1100, 5'b11000};

    PI_RST     = 1'b1;
    M68K_CLK   = 1'b0;
    STATUS_CLR = 1'b0;
    set_in(4'b1100);
    repeat (3) @(negedge PI_CLK);
    PI_RST = 1'b0;
    check("reset", 5'b11000);

    for (int i = 0; i < 42; i++) begin
      set_in(vecs[i].in);
      do_fall(1'b0);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Hold overrun with HOLD_MAX=16
    set_in(4'b0100);
    falls(3);
    check("hold_grant", 5'b00010);
    set_in(4'b0000);
    do_fall(1'b0);
    check("hold_ext_entry", 5'b10010);
    falls(15);
    check("hold_15", 5'b10010);
    do_fall(1'b0);
    check("hold_16_overrun", 5'b10011);
    falls(4);
    check("hold_sticky", 5'b10011);
    @(negedge PI_CLK);
    STATUS_CLR = 1'b1;
    @(negedge PI_CLK);
    STATUS_CLR = 1'b0;
    @(negedge PI_CLK);
    check("hold_clr", 5'b10010);
    do_fall(1'b0);
    check("hold_saturated_no_reset", 5'b10010);
    set_in(4'b1100);
    do_fall(1'b0);
    check("hold_recov", 5'b10000);
    falls(2);
    check("hold_own", 5'b11000);

    // Second tenure: clear coincident with the overrun set
    set_in(4'b0100);
    falls(3);
    set_in(4'b0000);
    do_fall(1'b0);
    falls(15);
    check("coinc_pre", 5'b10010);
    do_fall(1'b1);
    check("coinc_set_wins", 5'b10011);

    // Reset mid-EXT with overrun set
    PI_RST = 1'b1;
    @(negedge PI_CLK);
    check("rst_mid_ext", 5'b11000);
    repeat (2) @(negedge PI_CLK);
    check("rst_held", 5'b11000);
    set_in(4'b1110);
    PI_RST = 1'b0;
    do_fall(1'b0);
    check("rst_own_grant", 5'b11100);

    // Grant withdrawn after GRANT_TIMEOUT falls without BGACK_n
    set_in(4'b0100);
    falls(3);
    check("to_grant", 5'b00010);
    falls(31);
    check("to_31", 5'b00010);
    do_fall(1'b0);
    check("to_32_withdrawn", 5'b10000);
    set_in(4'b1100);
    falls(2);
    check("to_own", 5'b11000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
